// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared types and defaults for the ALSU command sequencer
package alsu_pkg;

   localparam int DEF_DATA_W = 3;
   localparam int DEF_OUT_W  = 6;
   localparam int DEF_CNT_W  = 3;

   typedef enum logic [2:0] {
      OR     = 3'd0,
      XOR    = 3'd1,
      ADD    = 3'd2,
      MULT   = 3'd3,
      SHIFT  = 3'd4,
      ROTATE = 3'd5,
      INV6   = 3'd6,
      INV7   = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      STEP  = 3'd2,
      ISSUE = 3'd3,
      WAIT1 = 3'd4,
      WAIT2 = 3'd5,
      RESP  = 3'd6
   } state_e;

   typedef struct packed {
      logic [2:0]                   opcode;
      logic signed [DEF_DATA_W-1:0] a;
      logic signed [DEF_DATA_W-1:0] b;
      logic                         cin;
      logic                         serial_in;
      logic                         direction;
      logic                         red_op_a;
      logic                         red_op_b;
      logic                         bypass_a;
      logic                         bypass_b;
      logic [DEF_CNT_W-1:0]         cnt;
   } alsu_cmd_t;

   function automatic logic is_shift_rot(input logic [2:0] op);
      return (op == 3'(SHIFT)) || (op == 3'(ROTATE));
   endfunction

endpackage

// File: rtl/alsu_inv_pred.sv
// rtl/alsu_inv_pred.sv - predicts whether the ALSU will flag a command invalid
module alsu_inv_pred
   import alsu_pkg::*;
(
   input  alsu_cmd_t cmd,
   output logic      inv,
   output logic      err,
   output logic      shift_cmd
);

   logic red_any;
   logic bypass_any;
   logic unused_bits;

   assign red_any    = cmd.red_op_a | cmd.red_op_b;
   assign bypass_any = cmd.bypass_a | cmd.bypass_b;

   assign inv = (red_any && (cmd.opcode[2:1] != 2'b00)) || (cmd.opcode[2:1] == 2'b11);
   assign err = inv && !bypass_any;

   // Only clean shift/rotate commands take the preload + step path.
   assign shift_cmd = is_shift_rot(cmd.opcode) && !inv && !bypass_any;

   assign unused_bits = ^{cmd.a, cmd.b, cmd.cin, cmd.serial_in, cmd.direction, cmd.cnt};

endmodule

// File: rtl/alsu_seq_ctrl.sv
// rtl/alsu_seq_ctrl.sv - one-command-at-a-time sequencer driving a 2-stage ALSU
module alsu_seq_ctrl
   import alsu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_opcode,
   input  logic signed [DATA_W-1:0] cmd_A,
   input  logic signed [DATA_W-1:0] cmd_B,
   input  logic                     cmd_cin,
   input  logic                     cmd_serial_in,
   input  logic                     cmd_direction,
   input  logic                     cmd_red_op_A,
   input  logic                     cmd_red_op_B,
   input  logic                     cmd_bypass_A,
   input  logic                     cmd_bypass_B,
   input  logic [CNT_W-1:0]         cmd_cnt,

   output logic signed [DATA_W-1:0] alsu_A,
   output logic signed [DATA_W-1:0] alsu_B,
   output logic [2:0]               alsu_opcode,
   output logic                     alsu_cin,
   output logic                     alsu_serial_in,
   output logic                     alsu_direction,
   output logic                     alsu_red_op_A,
   output logic                     alsu_red_op_B,
   output logic                     alsu_bypass_A,
   output logic                     alsu_bypass_B,
   input  logic [OUT_W-1:0]         alsu_out,

   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [OUT_W-1:0]         rsp_data,
   output logic                     rsp_err,
   output logic                     busy
);

   state_e           state;
   state_e           state_nxt;
   alsu_cmd_t        cmd_in;
   alsu_cmd_t        cmd_q;
   logic [CNT_W-1:0] step_cnt;
   logic             accept;
   logic             in_inv;
   logic             in_err;
   logic             in_shift;
   logic             err_q;

   assign cmd_in = '{
      opcode:    cmd_opcode,
      a:         cmd_A,
      b:         cmd_B,
      cin:       cmd_cin,
      serial_in: cmd_serial_in,
      direction: cmd_direction,
      red_op_a:  cmd_red_op_A,
      red_op_b:  cmd_red_op_B,
      bypass_a:  cmd_bypass_A,
      bypass_b:  cmd_bypass_B,
      cnt:       cmd_cnt
   };

   alsu_inv_pred u_inv_pred (
      .cmd       (cmd_in),
      .inv       (in_inv),
      .err       (in_err),
      .shift_cmd (in_shift)
   );

   assign accept = cmd_valid && (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = in_shift ? LOAD : ISSUE;
         LOAD:    state_nxt = STEP;
         STEP:    if (step_cnt == '0) state_nxt = WAIT1;
         ISSUE:   state_nxt = WAIT1;
         WAIT1:   state_nxt = WAIT2;
         WAIT2:   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Err is judged at accept time; in_inv is folded into it, the rest is datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q    <= '0;
         err_q    <= 1'b0;
         step_cnt <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (accept) begin
            cmd_q <= cmd_in;
            err_q <= in_err && in_inv;
         end
         if (state == LOAD) begin
            step_cnt <= cmd_q.cnt;
         end else if ((state == STEP) && (step_cnt != '0)) begin
            step_cnt <= step_cnt - 1'b1;
         end
         if (state == WAIT2) begin
            rsp_data <= alsu_out;
            rsp_err  <= err_q;
         end
      end
   end

   // Any state not listed drives the all-zero idle pattern (OR of 0 with 0).
   always_comb begin
      cmd_ready      = 1'b0;
      rsp_valid      = 1'b0;
      busy           = (state != IDLE);
      alsu_A         = '0;
      alsu_B         = '0;
      alsu_opcode    = 3'(OR);
      alsu_cin       = 1'b0;
      alsu_serial_in = 1'b0;
      alsu_direction = 1'b0;
      alsu_red_op_A  = 1'b0;
      alsu_red_op_B  = 1'b0;
      alsu_bypass_A  = 1'b0;
      alsu_bypass_B  = 1'b0;
      case (state)
         IDLE: cmd_ready = 1'b1;
         LOAD: begin
            alsu_bypass_A = 1'b1;
            alsu_A        = cmd_q.a;
         end
         STEP: begin
            alsu_opcode    = cmd_q.opcode;
            alsu_direction = cmd_q.direction;
            alsu_serial_in = cmd_q.serial_in;
         end
         ISSUE: begin
            alsu_A         = cmd_q.a;
            alsu_B         = cmd_q.b;
            alsu_opcode    = cmd_q.opcode;
            alsu_cin       = cmd_q.cin;
            alsu_serial_in = cmd_q.serial_in;
            alsu_direction = cmd_q.direction;
            alsu_red_op_A  = cmd_q.red_op_a;
            alsu_red_op_B  = cmd_q.red_op_b;
            alsu_bypass_A  = cmd_q.bypass_a;
            alsu_bypass_B  = cmd_q.bypass_b;
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alsu_seq_ctrl.sv
// tb/tb_alsu_seq_ctrl.sv - directed bench for alsu_seq_ctrl with a behavioural ALSU
module tb_alsu_seq_ctrl;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_opcode;
   logic signed [2:0] cmd_A;
   logic signed [2:0] cmd_B;
   logic              cmd_cin, cmd_serial_in, cmd_direction;
   logic              cmd_red_op_A, cmd_red_op_B, cmd_bypass_A, cmd_bypass_B;
   logic [2:0]        cmd_cnt;
   logic signed [2:0] alsu_A;
   logic signed [2:0] alsu_B;
   logic [2:0]        alsu_opcode;
   logic              alsu_cin, alsu_serial_in, alsu_direction;
   logic              alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
   logic [5:0]        alsu_out;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [5:0]        rsp_data;
   logic              rsp_err;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alsu_seq_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_opcode     (cmd_opcode),
      .cmd_A          (cmd_A),
      .cmd_B          (cmd_B),
      .cmd_cin        (cmd_cin),
      .cmd_serial_in  (cmd_serial_in),
      .cmd_direction  (cmd_direction),
      .cmd_red_op_A   (cmd_red_op_A),
      .cmd_red_op_B   (cmd_red_op_B),
      .cmd_bypass_A   (cmd_bypass_A),
      .cmd_bypass_B   (cmd_bypass_B),
      .cmd_cnt        (cmd_cnt),
      .alsu_A         (alsu_A),
      .alsu_B         (alsu_B),
      .alsu_opcode    (alsu_opcode),
      .alsu_cin       (alsu_cin),
      .alsu_serial_in (alsu_serial_in),
      .alsu_direction (alsu_direction),
      .alsu_red_op_A  (alsu_red_op_A),
      .alsu_red_op_B  (alsu_red_op_B),
      .alsu_bypass_A  (alsu_bypass_A),
      .alsu_bypass_B  (alsu_bypass_B),
      .alsu_out       (alsu_out),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .busy           (busy)
   );

   // Behavioural ALSU: registered inputs, then registered output.
   logic [2:0] a_r, b_r, op_r;
   logic       cin_r, ser_r, dir_r, roa_r, rob_r, bpa_r, bpb_r;

   function automatic logic [5:0] alsu_f(input logic [2:0] op, input logic [2:0] a,
                                         input logic [2:0] b, input logic cin, input logic ser,
                                         input logic dir, input logic roa, input logic rob,
                                         input logic bpa, input logic bpb, input logic [5:0] cur);
      logic [5:0] ae, be;
      ae = {{3{a[2]}}, a};
      be = {{3{b[2]}}, b};
      if (bpa) return ae;
      if (bpb) return be;
      if ((op[2:1] == 2'b11) || ((roa || rob) && (op[2:1] != 2'b00))) return 6'd0;
      case (op)
         3'd0:    return roa ? {5'd0, |a} : rob ? {5'd0, |b} : {3'd0, a | b};
         3'd1:    return roa ? {5'd0, ^a} : rob ? {5'd0, ^b} : {3'd0, a ^ b};
         3'd2:    return ae + be + {5'd0, cin};
         3'd3:    return ae * be;
         3'd4:    return dir ? {cur[4:0], ser} : {ser, cur[5:1]};
         3'd5:    return dir ? {cur[4:0], cur[5]} : {cur[0], cur[5:1]};
         default: return 6'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         {a_r, b_r, op_r} <= '0;
         {cin_r, ser_r, dir_r, roa_r, rob_r, bpa_r, bpb_r} <= '0;
         alsu_out <= '0;
      end else begin
         a_r   <= alsu_A;
         b_r   <= alsu_B;
         op_r  <= alsu_opcode;
         cin_r <= alsu_cin;
         ser_r <= alsu_serial_in;
         dir_r <= alsu_direction;
         roa_r <= alsu_red_op_A;
         rob_r <= alsu_red_op_B;
         bpa_r <= alsu_bypass_A;
         bpb_r <= alsu_bypass_B;
         alsu_out <= alsu_f(op_r, a_r, b_r, cin_r, ser_r, dir_r, roa_r, rob_r, bpa_r, bpb_r, alsu_out);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic cin, input logic ser, input logic dir,
                          input logic roa, input logic rob, input logic bpa, input logic bpb,
                          input logic [2:0] cnt);
      cmd_opcode    = op;
      cmd_A         = a;
      cmd_B         = b;
      cmd_cin       = cin;
      cmd_serial_in = ser;
      cmd_direction = dir;
      cmd_red_op_A  = roa;
      cmd_red_op_B  = rob;
      cmd_bypass_A  = bpa;
      cmd_bypass_B  = bpb;
      cmd_cnt       = cnt;
   endtask

   // Called at a negedge; latency counts cycles from the accept edge to rsp_valid.
   task automatic run_cmd(input string tag, input int exp_lat, input logic [5:0] exp_data,
                          input logic exp_err, input int hold);
      int n;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      check({tag, ".lat"}, 32'(n), 32'(exp_lat));
      check({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
      check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         check({tag, ".hold"}, {rsp_valid, cmd_ready, rsp_err, 23'd0, rsp_data},
               {1'b1, 1'b0, exp_err, 23'd0, exp_data});
      end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, ".done"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
   endtask

   initial begin
      int saw;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      set_cmd(3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset.flags", {27'd0, cmd_ready, busy, rsp_valid, rsp_err, 1'b0}, 32'h10);
      check("reset.data", 32'(rsp_data), 32'd0);
      check("reset.alsu", {alsu_opcode, alsu_A, alsu_B, alsu_bypass_A}, 32'd0);

      //      op    A       B       cin ser dir roa rob bpa bpb cnt
      set_cmd(3'd2, 3'd3,   3'd2,   1,  0,  0,  0,  0,  0,  0,  3'd0);
      run_cmd("add", 4, 6'd6, 0, 0);
      set_cmd(3'd3, 3'b110, 3'b011, 0,  0,  0,  0,  0,  0,  0,  3'd0);
      run_cmd("mult", 4, 6'b111010, 0, 0);
      set_cmd(3'd5, 3'b011, 3'd0,   0,  0,  1,  0,  0,  0,  0,  3'd1);
      run_cmd("rot_l", 6, 6'b001100, 0, 0);
      set_cmd(3'd5, 3'b011, 3'd0,   0,  0,  0,  0,  0,  0,  0,  3'd0);
      run_cmd("rot_r", 5, 6'b100001, 0, 0);
      set_cmd(3'd6, 3'b101, 3'd0,   0,  0,  0,  0,  0,  0,  0,  3'd0);
      run_cmd("inv6", 4, 6'd0, 1, 0);
      set_cmd(3'd6, 3'b101, 3'd0,   0,  0,  0,  0,  0,  1,  0,  3'd0);
      run_cmd("inv6_byp", 4, 6'b111101, 0, 0);
      set_cmd(3'd7, 3'd0,   3'b011, 0,  0,  0,  0,  0,  0,  1,  3'd0);
      run_cmd("inv7_bypb", 4, 6'b000011, 0, 0);
      set_cmd(3'd2, 3'd1,   3'd1,   0,  0,  0,  1,  0,  0,  0,  3'd0);
      run_cmd("add_red", 4, 6'd0, 1, 0);
      set_cmd(3'd4, 3'd1,   3'd0,   0,  1,  1,  1,  0,  0,  0,  3'd3);
      run_cmd("shift_red", 4, 6'd0, 1, 0);
      set_cmd(3'd0, 3'd0,   3'b100, 0,  0,  0,  0,  1,  0,  0,  3'd0);
      run_cmd("or_redb", 4, 6'd1, 0, 0);
      set_cmd(3'd4, 3'b010, 3'd0,   0,  1,  0,  0,  0,  0,  0,  3'd2);
      run_cmd("shift_bp", 7, 6'b111000, 0, 5);
      set_cmd(3'd4, 3'b001, 3'd0,   0,  1,  1,  0,  0,  0,  0,  3'd7);
      run_cmd("shift_8", 12, 6'b111111, 0, 0);

      // Reset while stepping a long shift: no response may follow.
      set_cmd(3'd4, 3'b011, 3'd0,   0,  1,  1,  0,  0,  0,  0,  3'd7);
      cmd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      check("rst.in_step", 32'(alsu_opcode), 32'd4);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check("rst.flags", {29'd0, cmd_ready, busy, rsp_valid}, 32'h4);
      check("rst.alsu", {alsu_opcode, alsu_A, alsu_B, alsu_serial_in, alsu_direction,
                         alsu_bypass_A}, 32'd0);
      saw = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); @(negedge clk);
         if (rsp_valid || busy) saw++;
      end
      check("rst.no_rsp", 32'(saw), 32'd0);

      // Reset and a valid command on the same edge: reset wins.
      set_cmd(3'd2, 3'd1,   3'd1,   0,  0,  0,  0,  0,  0,  0,  3'd0);
      cmd_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      cmd_valid = 1'b0;
      check("rst_cmd.idle", {30'd0, cmd_ready, busy}, 32'h2);

      set_cmd(3'd1, 3'b101, 3'b011, 0,  0,  0,  0,  0,  0,  0,  3'd0);
      run_cmd("xor", 4, 6'b000110, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
